// File: rtl/lutram_fifo_ctl.sv
// rtl/lutram_fifo_ctl.sv - 16-deep LUT RAM FIFO scheduler with shared-address arbitration and registered head
// Optional feature macro: LUTFIFO_BYPASS_EN (empty-FIFO words load straight into the output register)
module lutram_fifo_ctl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [4:0]   level,
    output logic [3:0]   ram_a,
    output logic         ram_we,
    output logic [W-1:0] ram_d,
    input  logic [W-1:0] ram_o
);

    logic [3:0]   r_wptr;
    logic [3:0]   r_rptr;
    logic [4:0]   r_cnt;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_prio;

    logic w_empty;
    logic w_full;
    logic w_head_free;
    logic w_rd_req;
    logic w_wr_req;
    logic w_bypass;
    logic w_conflict;
    logic w_gnt_rd;
    logic w_gnt_wr;
    logic w_clear;

    // Request, bypass and grant decode; the RAM address port serves one pointer per cycle
    always_comb begin
        w_empty     = (r_cnt == 5'd0);
        w_full      = (r_cnt == 5'd16);
        w_head_free = !r_out_valid || out_ready;
        w_rd_req    = !w_empty && w_head_free;
        w_wr_req    = in_valid && !w_full;
`ifdef LUTFIFO_BYPASS_EN
        w_bypass    = w_empty && w_head_free && in_valid;
`else
        w_bypass    = 1'b0;
`endif
        w_clear     = rst || flush;
        w_conflict  = w_rd_req && w_wr_req;
        w_gnt_rd    = w_rd_req && (!w_wr_req || !r_prio);
        // A bypassed word never touches the RAM, so its write request is dropped here
        w_gnt_wr    = w_wr_req && !w_bypass && (!w_rd_req || r_prio);
    end

    // RAM port and handshake outputs
    always_comb begin
        ram_we    = w_gnt_wr && !w_clear;
        ram_a     = w_gnt_wr ? r_wptr : r_rptr;
        ram_d     = in_data;
        in_ready  = !w_full && !(w_rd_req && !r_prio);
        out_valid = r_out_valid;
        out_data  = r_out_data;
        level     = r_cnt + {4'd0, r_out_valid};
    end

    // Pointer, count, head register and priority update; rst and flush discard everything in flight
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wptr      <= 4'd0;
            r_rptr      <= 4'd0;
            r_cnt       <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_prio      <= 1'b0;
        end else begin
            if (w_gnt_wr) begin
                r_wptr <= r_wptr + 4'd1;
                r_cnt  <= r_cnt + 5'd1;
            end
            if (w_gnt_rd) begin
                r_out_data  <= ram_o;
                r_out_valid <= 1'b1;
                r_rptr      <= r_rptr + 4'd1;
                r_cnt       <= r_cnt - 5'd1;
            end else if (w_bypass) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_conflict) begin
                r_prio <= !r_prio;
            end
        end
    end

endmodule
